// File: rtl/ram32x4_pkg.sv
// rtl/ram32x4_pkg.sv - shared widths and FSM encoding for the ram32x4 arbiter
// Purpose: common RAM geometry and state type, also reused by board wrappers.
// Ports: none (package).
package ram32x4_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

endpackage

// File: rtl/ram32x4_arbiter_if.sv
// rtl/ram32x4_arbiter_if.sv - requester, RAM and status signals of the ram32x4 arbiter
// Purpose: bundles both requester ports, the RAM-side port and busy.
// Modports:
//   slave  - arbiter view: sees requests and ram_q, drives grants, read data, RAM controls, busy.
//   master - environment view: requesters plus the RAM model.
interface ram32x4_arbiter_if;
  import ram32x4_pkg::*;

  // Requester A
  logic              a_req;
  logic              a_wren;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;
  logic              a_valid;
  logic [DATA_W-1:0] a_q;

  // Requester B
  logic              b_req;
  logic              b_wren;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;
  logic              b_valid;
  logic [DATA_W-1:0] b_q;

  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  // Status
  logic              busy;

  modport slave (
    input  a_req, a_wren, a_addr, a_data,
    input  b_req, b_wren, b_addr, b_data,
    input  ram_q,
    output a_gnt, a_valid, a_q,
    output b_gnt, b_valid, b_q,
    output ram_addr, ram_data, ram_wren,
    output busy
  );

  modport master (
    output a_req, a_wren, a_addr, a_data,
    output b_req, b_wren, b_addr, b_data,
    output ram_q,
    input  a_gnt, a_valid, a_q,
    input  b_gnt, b_valid, b_q,
    input  ram_addr, ram_data, ram_wren,
    input  busy
  );

endinterface

// File: rtl/ram32x4_arbiter_rr_arb2.sv
// rtl/ram32x4_arbiter_rr_arb2.sv - two-way round-robin grant logic with last-grant register
// Purpose: combinational one-hot grant from two requests, favouring the requester
//          not served most recently; remembers the winner of every grant cycle.
// Ports:
//   clk, resetn        - clock and synchronous active-low reset
//   i_en               - grants allowed this cycle
//   i_req_a, i_req_b   - requests
//   o_gnt_a, o_gnt_b   - grants, at most one high
module rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  // 1 = A won the most recent grant; reset to B so A goes first.
  logic r_last_a;

  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (i_en) begin
      // A wins when alone, or when both ask and B was served last.
      if (i_req_a && (!i_req_b || !r_last_a)) begin
        o_gnt_a = 1'b1;
      end else if (i_req_b) begin
        o_gnt_b = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_a <= 1'b0;
    end else if (o_gnt_a || o_gnt_b) begin
      r_last_a <= o_gnt_a;
    end
  end

endmodule

// File: rtl/ram32x4_arbiter.sv
// rtl/ram32x4_arbiter.sv - two-requester arbiter in front of a 32x4 RAM with init sweep
// Purpose: optionally fills the RAM with INIT_VALUE after reset, then serves
//          requesters A and B one access per cycle with round-robin fairness.
// Ports:
//   clk     - clock
//   resetn  - synchronous active-low reset
//   bus     - slave modport: a_*/b_* requester ports, ram_* RAM port, busy
// Parameters:
//   INIT_VALUE  - word written to every location by the sweep
//   INIT_ENABLE - 1 runs the sweep after reset, 0 starts arbitrating at once
module ram32x4_arbiter
  import ram32x4_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VALUE  = 4'h0,
  parameter bit                INIT_ENABLE = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  ram32x4_arbiter_if.slave   bus
);

  localparam state_t RESET_STATE = INIT_ENABLE ? ST_INIT : ST_ARB;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_a_valid;
  logic              r_b_valid;

  logic              w_arb_en;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data;
  logic              w_ram_wren;
  logic              w_busy;

  // Grants are suppressed in reset as well as during the sweep.
  assign w_arb_en = resetn && (r_state == ST_ARB);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .resetn  (resetn),
    .i_en    (w_arb_en),
    .i_req_a (bus.a_req),
    .i_req_b (bus.b_req),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and RAM-side mux. Without an active driver the RAM address and
  // data stay at whatever was last presented, via the hold registers.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_addr  = r_hold_addr;
    w_ram_data  = r_hold_data;
    w_ram_wren  = 1'b0;
    w_busy      = 1'b0;
    if (!resetn) begin
      w_busy = INIT_ENABLE;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_busy     = 1'b1;
          w_ram_addr = r_cnt;
          w_ram_data = INIT_VALUE;
          w_ram_wren = 1'b1;
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_gnt_a) begin
            w_ram_addr = bus.a_addr;
            w_ram_data = bus.a_data;
            w_ram_wren = bus.a_wren;
          end else if (w_gnt_b) begin
            w_ram_addr = bus.b_addr;
            w_ram_data = bus.b_data;
            w_ram_wren = bus.b_wren;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
    end else begin
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_hold_addr <= w_ram_addr;
      r_hold_data <= w_ram_data;
      // RAM registers the address this cycle, so q is valid next cycle.
      r_a_valid   <= w_gnt_a & ~bus.a_wren;
      r_b_valid   <= w_gnt_b & ~bus.b_wren;
    end
  end

  assign bus.a_gnt    = w_gnt_a;
  assign bus.b_gnt    = w_gnt_b;
  // A reset landing in the data cycle aborts the read.
  assign bus.a_valid  = r_a_valid & resetn;
  assign bus.b_valid  = r_b_valid & resetn;
  assign bus.a_q      = bus.ram_q;
  assign bus.b_q      = bus.ram_q;
  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_data = w_ram_data;
  assign bus.ram_wren = w_ram_wren;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// tb/tb_ram32x4_arbiter.sv - self-checking bench for ram32x4_arbiter
module tb_ram32x4_arbiter;
  import ram32x4_pkg::*;

  typedef struct packed {
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  localparam logic [7:0] TAG_A = 8'h41;
  localparam logic [7:0] TAG_B = 8'h42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn0;
  logic resetn1;
  logic mem_load;

  ram32x4_arbiter_if if0 ();
  ram32x4_arbiter_if if1 ();

  ram32x4_arbiter #(.INIT_VALUE(4'h5), .INIT_ENABLE(1'b1)) dut0 (
    .clk(clk), .resetn(resetn0), .bus(if0)
  );
  ram32x4_arbiter #(.INIT_VALUE(4'hE), .INIT_ENABLE(1'b0)) dut1 (
    .clk(clk), .resetn(resetn1), .bus(if1)
  );

  // RAM models: registered address/data/wren, unregistered q.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [ADDR_W-1:0] r_addr0;
  logic [ADDR_W-1:0] r_addr1;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem0[i] <= 4'($urandom);
        mem1[i] <= 4'(i * 3 + 1);
      end
    end else begin
      if (if0.ram_wren) mem0[if0.ram_addr] <= if0.ram_data;
      if (if1.ram_wren) mem1[if1.ram_addr] <= if1.ram_data;
    end
    r_addr0 <= if0.ram_addr;
    r_addr1 <= if1.ram_addr;
  end

  assign if0.ram_q = mem0[r_addr0];
  assign if1.ram_q = mem1[r_addr1];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for dut0: expected RAM contents plus who was served last.
  logic [DATA_W-1:0] model0 [DEPTH];
  bit                last_was_a;
  bit                exp_va, exp_vb;
  logic [DATA_W-1:0] exp_qa, exp_qb;
  int                wait_a, wait_b;
  txn_t              qa[$];
  txn_t              qb[$];
  logic [7:0]        order[$];
  logic [DATA_W-1:0] a_reads[$];
  logic [DATA_W-1:0] b_reads[$];
  int                cnt;
  bit                done;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    txn_t t;
    t.w = w; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn(input int max_addr);
    return mk(1'($urandom), 5'($urandom_range(max_addr, 0)), 4'($urandom));
  endfunction

  // One ARB cycle on dut0, entered and left at posedge+1.
  task automatic step0();
    txn_t ta, tb;
    logic pa, pb, ga, gb;
    pa = (qa.size() > 0);
    pb = (qb.size() > 0);
    ta = pa ? qa[0] : rnd_txn(31);
    tb = pb ? qb[0] : rnd_txn(31);
    if0.a_req = pa; if0.a_wren = ta.w; if0.a_addr = ta.addr; if0.a_data = ta.data;
    if0.b_req = pb; if0.b_wren = tb.w; if0.b_addr = tb.addr; if0.b_data = tb.data;
    #1;
    chk("busy_arb", 8'(if0.busy), 8'd0);
    chk("a_valid", 8'(if0.a_valid), 8'(exp_va));
    if (exp_va) begin
      chk("a_q", 8'(if0.a_q), 8'(exp_qa));
      a_reads.push_back(if0.a_q);
    end
    chk("b_valid", 8'(if0.b_valid), 8'(exp_vb));
    if (exp_vb) begin
      chk("b_q", 8'(if0.b_q), 8'(exp_qb));
      b_reads.push_back(if0.b_q);
    end
    ga = pa && (!pb || !last_was_a);
    gb = pb && !ga;
    chk("a_gnt", 8'(if0.a_gnt), 8'(ga));
    chk("b_gnt", 8'(if0.b_gnt), 8'(gb));
    exp_va = 1'b0;
    exp_vb = 1'b0;
    if (ga) begin
      chk("ram_wren_a", 8'(if0.ram_wren), 8'(ta.w));
      chk("ram_addr_a", 8'(if0.ram_addr), 8'(ta.addr));
      chk("ram_data_a", 8'(if0.ram_data), 8'(ta.data));
      if (ta.w) model0[ta.addr] = ta.data;
      else begin exp_va = 1'b1; exp_qa = model0[ta.addr]; end
      void'(qa.pop_front());
      order.push_back(TAG_A);
      last_was_a = 1'b1;
    end
    if (gb) begin
      chk("ram_wren_b", 8'(if0.ram_wren), 8'(tb.w));
      chk("ram_addr_b", 8'(if0.ram_addr), 8'(tb.addr));
      chk("ram_data_b", 8'(if0.ram_data), 8'(tb.data));
      if (tb.w) model0[tb.addr] = tb.data;
      else begin exp_vb = 1'b1; exp_qb = model0[tb.addr]; end
      void'(qb.pop_front());
      order.push_back(TAG_B);
      last_was_a = 1'b0;
    end
    if (!ga && !gb) chk("ram_wren_idle", 8'(if0.ram_wren), 8'd0);
    if (pa && !ga) wait_a++; else wait_a = 0;
    if (pb && !gb) wait_b++; else wait_b = 0;
    chk("a_wait_bound", 8'(wait_a <= 1), 8'd1);
    chk("b_wait_bound", 8'(wait_b <= 1), 8'd1);
    @(posedge clk); #1;
  endtask

  task automatic run0(input int bound);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < bound) begin
      step0();
      n++;
    end
    step0();
    chk("drain", 8'(qa.size() + qb.size()), 8'd0);
  endtask

  task automatic clear_logs();
    order.delete();
    a_reads.delete();
    b_reads.delete();
  endtask

  task automatic idle_inputs();
    if0.a_req = 0; if0.a_wren = 0; if0.a_addr = 0; if0.a_data = 0;
    if0.b_req = 0; if0.b_wren = 0; if0.b_addr = 0; if0.b_data = 0;
    if1.a_req = 0; if1.a_wren = 0; if1.a_addr = 0; if1.a_data = 0;
    if1.b_req = 0; if1.b_wren = 0; if1.b_addr = 0; if1.b_data = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_load = 1'b1;
    resetn0  = 1'b0;
    resetn1  = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    mem_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, requests asserted to show they are ignored
    if0.a_req = 1; if0.b_req = 1; if1.a_req = 1;
    #1;
    chk("rst_busy0", 8'(if0.busy), 8'd1);
    chk("rst_busy1", 8'(if1.busy), 8'd0);
    chk("rst_wren0", 8'(if0.ram_wren), 8'd0);
    chk("rst_a_gnt0", 8'(if0.a_gnt), 8'd0);
    chk("rst_b_gnt0", 8'(if0.b_gnt), 8'd0);
    chk("rst_a_gnt1", 8'(if1.a_gnt), 8'd0);
    chk("rst_a_valid0", 8'(if0.a_valid), 8'd0);
    chk("rst_b_valid0", 8'(if0.b_valid), 8'd0);
    chk("rst_ram_addr0", 8'(if0.ram_addr), 8'd0);
    chk("rst_ram_data0", 8'(if0.ram_data), 8'd0);
    idle_inputs();
    @(posedge clk); #1;

    // Partial sweep, reset at address 17
    resetn0 = 1'b1;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (if0.ram_addr == 5'd17) done = 1;
      else begin @(posedge clk); #1; end
    end
    chk("sweep_reach17", 8'(if0.ram_addr), 8'd17);
    resetn0 = 1'b0;
    #1;
    chk("midrst_wren", 8'(if0.ram_wren), 8'd0);
    chk("midrst_busy", 8'(if0.busy), 8'd1);
    @(posedge clk); #1;
    chk("midrst_wren2", 8'(if0.ram_wren), 8'd0);
    chk("midrst_addr", 8'(if0.ram_addr), 8'd0);
    @(posedge clk); #1;
    resetn0 = 1'b1;

    // Full sweep with both requests held high
    cnt = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if0.a_req = 1; if0.b_req = 1;
      #1;
      if (if0.busy) begin
        chk("sweep_addr", 8'(if0.ram_addr), 8'(cnt));
        chk("sweep_wren", 8'(if0.ram_wren), 8'd1);
        chk("sweep_data", 8'(if0.ram_data), 8'h5);
        chk("sweep_a_gnt", 8'(if0.a_gnt), 8'd0);
        chk("sweep_b_gnt", 8'(if0.b_gnt), 8'd0);
        cnt++;
        @(posedge clk); #1;
      end else begin
        if0.a_req = 0; if0.b_req = 0;
        done = 1;
      end
    end
    chk("sweep_len", 8'(cnt), 8'd32);

    for (int i = 0; i < DEPTH; i++) model0[i] = 4'h5;
    last_was_a = 1'b0;
    exp_va = 0; exp_vb = 0; wait_a = 0; wait_b = 0;

    // Post-sweep read returns the init value
    clear_logs();
    qb.push_back(mk(1'b0, 5'd20, 4'h0));
    run0(10);
    chk("init_rd_n", 8'(b_reads.size()), 8'd1);
    if (b_reads.size() == 1) chk("init_rd_q", 8'(b_reads[0]), 8'h5);

    // Single write/read by A
    clear_logs();
    qa.push_back(mk(1'b1, 5'h13, 4'hA));
    qa.push_back(mk(1'b0, 5'h13, 4'h0));
    run0(10);
    chk("wr_rd_ngnt", 8'(order.size()), 8'd2);
    foreach (order[i]) chk("wr_rd_only_a", order[i], TAG_A);
    chk("wr_rd_nreads", 8'(a_reads.size()), 8'd1);
    if (a_reads.size() == 1) chk("wr_rd_q", 8'(a_reads[0]), 8'hA);

    // B served last so that A leads the contention run
    qb.push_back(mk(1'b1, 5'h01, 4'h3));
    run0(10);

    // Contention: four reads each
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b0, 5'h13, 4'h0));
      qb.push_back(mk(1'b0, 5'h01, 4'h0));
    end
    run0(20);
    chk("cont_ngnt", 8'(order.size()), 8'd8);
    foreach (order[i]) chk("cont_order", order[i], (i % 2 == 0) ? TAG_A : TAG_B);
    chk("cont_na", 8'(a_reads.size()), 8'd4);
    chk("cont_nb", 8'(b_reads.size()), 8'd4);
    foreach (a_reads[i]) chk("cont_a_q", 8'(a_reads[i]), 8'hA);
    foreach (b_reads[i]) chk("cont_b_q", 8'(b_reads[i]), 8'h3);

    // Write-then-read on address 0
    clear_logs();
    qb.push_back(mk(1'b1, 5'h00, 4'h7));
    qa.push_back(mk(1'b0, 5'h00, 4'h0));
    qa.push_back(mk(1'b0, 5'h00, 4'h0));
    run0(10);
    chk("wtr_ngnt", 8'(order.size()), 8'd3);
    if (order.size() == 3) begin
      chk("wtr_order0", order[0], TAG_A);
      chk("wtr_order1", order[1], TAG_B);
      chk("wtr_order2", order[2], TAG_A);
    end
    chk("wtr_nreads", 8'(a_reads.size()), 8'd2);
    if (a_reads.size() == 2) begin
      chk("wtr_old", 8'(a_reads[0]), 8'h5);
      chk("wtr_new", 8'(a_reads[1]), 8'h7);
    end

    // Randomized traffic on a few hot addresses
    for (int c = 0; c < 300; c++) begin
      if (qa.size() == 0 && $urandom_range(3, 0) != 0) qa.push_back(rnd_txn(3));
      if (qb.size() == 0 && $urandom_range(3, 0) != 0) qb.push_back(rnd_txn(3));
      step0();
    end
    run0(20);

    // Reset in the data cycle of a read aborts it
    if0.a_req = 1; if0.a_wren = 0; if0.a_addr = 5'd3; if0.b_req = 0;
    #1;
    chk("abort_gnt", 8'(if0.a_gnt), 8'd1);
    @(posedge clk); #1;
    resetn0 = 1'b0;
    if0.a_req = 0;
    #1;
    chk("abort_valid", 8'(if0.a_valid), 8'd0);

    // INIT_ENABLE = 0: immediate grant, never busy
    @(posedge clk); #1;
    resetn1 = 1'b1;
    if1.a_req = 1; if1.a_wren = 0; if1.a_addr = 5'd9;
    #1;
    chk("d1_busy0", 8'(if1.busy), 8'd0);
    chk("d1_a_gnt", 8'(if1.a_gnt), 8'd1);
    chk("d1_b_gnt0", 8'(if1.b_gnt), 8'd0);
    @(posedge clk); #1;
    if1.a_req = 0;
    if1.b_req = 1; if1.b_wren = 1; if1.b_addr = 5'd2; if1.b_data = 4'h9;
    #1;
    chk("d1_a_valid", 8'(if1.a_valid), 8'd1);
    chk("d1_a_q", 8'(if1.a_q), 8'hC);
    chk("d1_b_gnt_w", 8'(if1.b_gnt), 8'd1);
    @(posedge clk); #1;
    if1.b_wren = 0;
    #1;
    chk("d1_a_valid_once", 8'(if1.a_valid), 8'd0);
    chk("d1_b_gnt_r", 8'(if1.b_gnt), 8'd1);
    chk("d1_b_valid_w", 8'(if1.b_valid), 8'd0);
    @(posedge clk); #1;
    if1.b_req = 0;
    #1;
    chk("d1_b_valid", 8'(if1.b_valid), 8'd1);
    chk("d1_b_q", 8'(if1.b_q), 8'h9);
    chk("d1_busy1", 8'(if1.busy), 8'd0);
    @(posedge clk); #1;
    chk("d1_b_valid_once", 8'(if1.b_valid), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram32x4_arbiter.md
RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 Parameter INIT_VALUE, default 4'h0: data word written to all 32 RAM locations during initialisation.
REQ-002 Parameter INIT_ENABLE, default 1: when 1, the block runs the initialisation sweep after reset; when 0, it goes directly to ARB.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low. Ports: clk input 1, the single clock; resetn input 1, synchronous reset, active-low.
REQ-004 Requester A ports SHALL be:
- a_req in 1: request.
- a_wren in 1: 1 = write, 0 = read.
- a_addr in 5: word address.
- a_data in 4: write data.
- a_gnt out 1: grant.
- a_valid out 1: read data valid.
- a_q out 4: read data.
REQ-005 Requester B ports SHALL be b_req, b_wren, b_addr, b_data, b_gnt, b_valid, b_q, with widths and meanings identical to REQ-004.
REQ-006 RAM-side ports SHALL be:
- ram_addr out 5: RAM address.
- ram_data out 4: RAM write data.
- ram_wren out 1: RAM write enable.
- ram_q in 4: RAM read data.
These connect to a ram32x4 with registered address/data/wren inputs and an unregistered q output.
REQ-007 Status port: busy out 1, high while the initialisation sweep is running.

Function
REQ-008 The FSM SHALL have exactly two states: INIT and ARB.
REQ-009 INIT: a 5-bit counter drives ram_addr; ram_data = INIT_VALUE; ram_wren = 1. The counter increments each cycle from 0 to 31, then the FSM enters ARB. The sweep takes 32 cycles. busy = 1 throughout INIT and 0 in ARB.
REQ-010 In INIT, a_gnt and b_gnt SHALL be 0 regardless of requests; pending requests wait.
REQ-011 In ARB, grants SHALL be combinational from req and a 1-bit last-grant register:
- Only one requester asserting req: that requester is granted.
- Both asserting req: the requester not granted most recently is granted.
- At most one gnt is high in any cycle.
REQ-012 The last-grant register SHALL update on every cycle in which a grant is issued.
REQ-013 In a grant cycle, ram_addr, ram_data and ram_wren SHALL be driven from the granted requester. With no grant, ram_wren = 0 and ram_addr/ram_data hold their last values.
REQ-014 Each requester holds req, wren, addr and data stable until it samples its own gnt high at a clock edge. Each grant completes one access; a requester that keeps req high receives back-to-back grants when uncontested.
REQ-015 Read latency:
- A read granted in cycle N produces x_valid = 1 in cycle N+1 only.
- x_q = ram_q in that cycle.
- x_q is don't-care when x_valid = 0.
- Writes never assert x_valid.
REQ-016 Under contention, grants SHALL alternate A, B, A, B. Neither requester waits more than 1 cycle in ARB.
REQ-017 Simultaneous read and write to the same address SHALL be serialised by the arbiter. A read granted one cycle after a write to the same address returns the new data.
REQ-018 Read-valid tracking SHALL be a registered per-requester flag, set on a read grant and cleared the following cycle.

Reset
REQ-019 When resetn = 0 at a clock edge, the following SHALL be loaded:
- State = INIT if INIT_ENABLE, else ARB.
- Init counter = 0.
- Last-grant = B, so A has priority first.
- a_valid = b_valid = 0.
- ram_addr = 0, ram_data = 0.
REQ-020 While resetn = 0: ram_wren, a_gnt and b_gnt SHALL be 0, and busy = INIT_ENABLE.
REQ-021 Reset asserted mid-sweep or mid-access SHALL abort the operation. No x_valid is produced for an aborted read, and the sweep restarts from address 0.

Structure
REQ-022 The shared package ram32x4_pkg SHALL hold ADDR_W = 5, DATA_W = 4, DEPTH = 32 and the state encoding INIT/ARB. The decoder_hex_16 board wrapper reuses ADDR_W and DATA_W.
REQ-023 One sub-module, rr_arb2, SHALL implement the 2-way round-robin grant logic and last-grant register. FSM, counter and muxing remain in ram32x4_arbiter.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Init sweep: reset released, INIT_VALUE = 4'h5 → busy high exactly 32 cycles, ram_wren high with addresses 0..31. Reading any address afterwards returns 4'h5.
- Single write/read: A writes 4'hA at 5'h13, then reads 5'h13 → a_gnt one cycle each; a_valid one cycle after the read grant with a_q = 4'hA; b_gnt stays 0.
- Contention: A and B both hold req for 4 reads → grant order A, B, A, B. Each x_valid arrives one cycle after its own grant with the correct data.
- Write-then-read: B writes 4'h7 at 5'h00 while A requests a read of 5'h00 in the same cycle. A is granted first and returns the old value; the read is repeated after B's grant and returns 4'h7.
- Mid-sweep reset: resetn low at sweep address 17 → ram_wren = 0 during reset. After release, the sweep restarts at address 0 and lasts 32 cycles.
- INIT_ENABLE = 0: a_req high in the first cycle after reset → immediate a_gnt, busy never high.
